jk_bank_driver: RTL and testbench
=================================

# jk_bank_driver

Drives a bank of WIDTH JK flip-flops (async active-low preset/clear, posedge clock) to requested target states and checks the result. Each request either loads a value directly through the flops' preset/clear pins or steps the bank through its J/K inputs. The block computes the excitation from its tracked copy of the bank state, waits for the flops to settle, then compares their q feedback against the target. It sits between a sequencing controller and the flop bank, as the stimulus-and-check end of the flop interface.

## Interface
- WIDTH, 4: number of flops in the bank.
- SETTLE, 1: cycles between the end of drive and the q compare; legal range 1..15.
- clk  in  1  rising-edge clock, shared with the flop bank.
- clear  in  1  asynchronous, active-low reset.
- tgt_valid  in  1  request valid.
- tgt_ready  out  1  request accepted when tgt_valid && tgt_ready at a clk edge.
- tgt_value  in  WIDTH  target bank state.
- tgt_init  in  1  1 = load via preset/clear; 0 = step via J/K.
- q  in  WIDTH  flop outputs (feedback).
- j, k  out  WIDTH  per-flop J/K inputs.
- ff_preset, ff_clear  out  WIDTH  per-flop active-low preset and clear.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: compare finished.
- mismatch  out  1  valid with done: OR of mismatch_bits.
- mismatch_bits  out  WIDTH  valid with done: q XOR target.

## Operation
- States are RST, IDLE, DRIVE, WAIT and CHECK.
  - RST: entered on reset. Holds ff_clear all 0. Goes to IDLE at the first edge after clear releases.
  - IDLE: tgt_ready=1. On accept, latch tgt_value and tgt_init, then go to DRIVE.
  - DRIVE: lasts exactly one cycle.
  - WAIT: lasts SETTLE cycles, counted by an internal counter.
  - CHECK: lasts one cycle. At its closing edge, register done=1, mismatch_bits=q^target and mismatch, then return to IDLE.
- tgt_ready is 1 only in IDLE.
- Internal expect register tracks the bank state:
  - Reset value 0, matching the reset-time clear of the flops.
  - Loaded from sampled q at the CHECK edge, so later excitation follows the real bank state even after a mismatch.
- J/K step (tgt_init=0), per-bit excitation from (expect, target):
  - 0→0 and 1→1: J=0, K=0 (hold).
  - 0→1: J=1, K=0.
  - 1→0: J=0, K=1.
  - J=K=1 is never driven.
  - j/k hold these values only during DRIVE and are 0 in every other state.
- Init load (tgt_init=1), during DRIVE only:
  - ff_preset[i]=0 where target[i]=1.
  - ff_clear[i]=0 where target[i]=0.
  - Preset and clear are never both low on the same bit.
  - Outside DRIVE and RST both are all 1.
  - j/k stay 0 during an init load.
- Reset values:
  - State is RST.
  - j=k=0, ff_preset all 1, ff_clear all 0.
  - busy=1, tgt_ready=0, done=0, mismatch=0, mismatch_bits=0, expect=0.
- Reset mid-operation: the in-flight request is dropped, no done is produced, and all outputs take their reset values immediately.
- A target equal to expect is still a full operation: hold excitation, compare, done.
- All outputs are registered.

## Timing
- Accept edge E0. DRIVE is the cycle E0→E1; the flops capture J/K at E1.
- WAIT covers E1→E1+SETTLE; CHECK covers the following cycle.
- done is high in the first IDLE cycle, which starts at edge E0+SETTLE+2.
- The earliest next accept is edge E0+SETTLE+3, giving throughput of 1 request per SETTLE+3 cycles.
- For an init load, q changes asynchronously during DRIVE; the compare timing is unchanged.

## Configuration
- Macro JKDRV_ERR_COUNT_EN.
  - Defined: adds output err_count[7:0]. It increments on each done with mismatch=1 and saturates at 255; reset value 0.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Package jk_pkg holds:
  - The state enum (RST, IDLE, DRIVE, WAIT, CHECK).
  - Excitation constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10.
  - The SETTLE counter width constant (4).
- Sub-module jk_excite: purely combinational per-bit (expect, target) → {j,k}, instantiated WIDTH times.

## Test plan
All scenarios use WIDTH=4 and SETTLE=1, with the bench instantiating 4 JK flops on clk.
- Reset release:
  - ff_clear=0000 through the first edge, q=0000.
  - tgt_ready rises one cycle later.
  - No done.
- Init load 1010:
  - In DRIVE, ff_preset=0101 and ff_clear=1010, with j=k=0000.
  - q=1010; done at E0+3 with mismatch=0.
- J/K step 1010→0110:
  - In DRIVE, j=0100 and k=1000.
  - q=0110, mismatch=0.
  - Next accept no earlier than E0+4.
- Fault on bit 0: flop 0 is stuck at 0 in the bench and target is 0001.
  - mismatch=1, mismatch_bits=0001.
  - expect=0000, so a repeat of the same request drives j=0001 again.
  - With JKDRV_ERR_COUNT_EN defined, err_count=1, then 2.
- Reset in WAIT:
  - clear is asserted during WAIT.
  - No done; ff_clear=0000 immediately; expect=0.
- Back-to-back requests: tgt_valid is held high with targets 1111, 0000, 0011.
  - Three done pulses, spaced 4 cycles apart, all with mismatch=0.
  - J=K=1 is never observed.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: shared types and constants for the JK flop bank driver.
//   state_e  - controller states (RST, IDLE, DRIVE, WAIT, CHECK)
//   JK_*     - per-bit {j,k} excitation codes
//   CNT_W    - width of the settle counter (SETTLE fits in 1..15)
package jk_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK
   } state_e;

   // {j,k} codes; JK toggle (2'b11) is deliberately absent
   localparam logic [1:0] JK_HOLD  = 2'b00;
   localparam logic [1:0] JK_RESET = 2'b01;
   localparam logic [1:0] JK_SET   = 2'b10;

   localparam int CNT_W = 4;

endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational JK excitation for one flop.
// Ports:
//   exp_bit - current (tracked) state of the flop
//   tgt_bit - requested next state
//   jk      - {j,k}: hold, set or reset; toggle is never produced
module jk_excite
   import jk_pkg::*;
(
   input  logic       exp_bit,
   input  logic       tgt_bit,
   output logic [1:0] jk
);

   always_comb begin
      jk = JK_HOLD;
      if (!exp_bit && tgt_bit)      jk = JK_SET;
      else if (exp_bit && !tgt_bit) jk = JK_RESET;
   end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a bank of WIDTH JK flops to a requested state, either
// by async preset/clear load or by one J/K clock step, then compares q.
// Optional feature: define JKDRV_ERR_COUNT_EN to add err_count[7:0], a
// saturating count of completed requests that ended in a mismatch.
// Ports:
//   clk, clear           - clock shared with the flop bank; async active-low reset
//   tgt_valid/ready      - request handshake; tgt_value target, tgt_init 1=load
//   q                    - flop outputs fed back for the compare
//   j, k                 - J/K inputs (non-zero only in DRIVE for a step)
//   ff_preset, ff_clear  - active-low async controls (DRIVE for a load, RST)
//   busy, done           - not-IDLE flag; one-cycle compare-complete pulse
//   mismatch(_bits)      - compare result, valid with done
module jk_bank_driver
   import jk_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_value,
   input  logic             tgt_init,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] ff_preset,
   output logic [WIDTH-1:0] ff_clear,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
`ifdef JKDRV_ERR_COUNT_EN
   output logic [WIDTH-1:0] mismatch_bits,
   output logic [7:0]       err_count
`else
   output logic [WIDTH-1:0] mismatch_bits
`endif
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
   logic [WIDTH-1:0] pre_q, pre_d, clr_q, clr_d;
   logic [WIDTH-1:0] mmb_q, mmb_d;
   logic             mm_q, mm_d, done_q, done_d;
   logic             busy_q, busy_d, ready_q, ready_d;
   logic             accept;
   logic [WIDTH-1:0] exc_j, exc_k, diff;

   // Excitation is taken against the incoming target while in IDLE so that
   // j/k can be registered at the accept edge and be stable for all of DRIVE.
   for (genvar i = 0; i < WIDTH; i++) begin : g_exc
      logic [1:0] jk;
      jk_excite u_exc (.exp_bit(exp_q[i]), .tgt_bit(tgt_value[i]), .jk(jk));
      assign exc_j[i] = jk[1];
      assign exc_k[i] = jk[0];
   end

   assign accept = (state_q == ST_IDLE) && tgt_valid;
   assign diff   = q ^ tgt_q;

   // State register
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= ST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RST:   state_d = ST_IDLE;
         ST_IDLE:  if (tgt_valid) state_d = ST_DRIVE;
         ST_DRIVE: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(SETTLE - 1);
         end
         ST_WAIT:  if (cnt_q == '0) state_d = ST_CHECK;
                   else             cnt_d   = cnt_q - 1'b1;
         ST_CHECK: state_d = ST_IDLE;
         default:  state_d = ST_RST;
      endcase
   end

   // Outputs, computed for the cycle that follows the coming edge
   always_comb begin
      j_d     = '0;
      k_d     = '0;
      pre_d   = '1;
      clr_d   = '1;
      done_d  = 1'b0;
      mmb_d   = '0;
      mm_d    = 1'b0;
      tgt_d   = tgt_q;
      exp_d   = exp_q;
      if (accept) begin
         tgt_d = tgt_value;
         if (tgt_init) begin
            // one of the two is low per bit, never both
            pre_d = ~tgt_value;
            clr_d = tgt_value;
         end else begin
            j_d = exc_j;
            k_d = exc_k;
         end
      end
      if (state_q == ST_CHECK) begin
         done_d = 1'b1;
         mmb_d  = diff;
         mm_d   = |diff;
         // follow the real bank so a faulty bit is re-driven next time
         exp_d  = q;
      end
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         j_q     <= '0;
         k_q     <= '0;
         pre_q   <= '1;
         clr_q   <= '0;
         done_q  <= 1'b0;
         mmb_q   <= '0;
         mm_q    <= 1'b0;
         tgt_q   <= '0;
         exp_q   <= '0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         j_q     <= j_d;
         k_q     <= k_d;
         pre_q   <= pre_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
         mmb_q   <= mmb_d;
         mm_q    <= mm_d;
         tgt_q   <= tgt_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign j             = j_q;
   assign k             = k_q;
   assign ff_preset     = pre_q;
   assign ff_clear      = clr_q;
   assign done          = done_q;
   assign mismatch      = mm_q;
   assign mismatch_bits = mmb_q;
   assign busy          = busy_q;
   assign tgt_ready     = ready_q;

`ifdef JKDRV_ERR_COUNT_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == ST_CHECK && (|diff) && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) err_q <= '0;
      else        err_q <= err_d;
   end

   assign err_count = err_q;
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: bench for jk_bank_driver with a behavioural 4-flop JK
// bank on clk (bit 0 can be forced stuck-at-0) and a request-level model.
// Honours JKDRV_ERR_COUNT_EN when defined.
module tb_jk_bank_driver;

   localparam int W = 4;
   localparam int S = 1;

   logic         clk = 1'b0;
   logic         clear = 1'b0;
   logic         tgt_valid = 1'b0;
   logic         tgt_init = 1'b0;
   logic [W-1:0] tgt_value = '0;
   logic         tgt_ready, busy, done, mismatch;
   logic [W-1:0] q, j, k, ff_preset, ff_clear, mismatch_bits, bank;
   logic         stuck0 = 1'b0;
`ifdef JKDRV_ERR_COUNT_EN
   logic [7:0]   err_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [W-1:0] mdl_exp = '0;   // bank state the driver should believe
   int           mdl_err = 0;

   always #5 clk = ~clk;

   jk_bank_driver #(.WIDTH(W), .SETTLE(S)) dut (
      .clk(clk), .clear(clear), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .tgt_value(tgt_value), .tgt_init(tgt_init), .q(q), .j(j), .k(k),
      .ff_preset(ff_preset), .ff_clear(ff_clear), .busy(busy), .done(done),
      .mismatch(mismatch),
`ifdef JKDRV_ERR_COUNT_EN
      .mismatch_bits(mismatch_bits), .err_count(err_count)
`else
      .mismatch_bits(mismatch_bits)
`endif
   );

   // Behavioural JK flops with async active-low clear (dominant) and preset
   for (genvar i = 0; i < W; i++) begin : g_ff
      logic b;
      always @(posedge clk or negedge ff_preset[i] or negedge ff_clear[i]) begin
         if (!ff_clear[i])       b <= 1'b0;
         else if (!ff_preset[i]) b <= 1'b1;
         else case ({j[i], k[i]})
            2'b01:   b <= 1'b0;
            2'b10:   b <= 1'b1;
            2'b11:   b <= ~b;
            default: b <= b;
         endcase
      end
      assign bank[i] = b;
   end
   assign q = stuck0 ? {bank[W-1:1], 1'b0} : bank;

   // Illegal drive combinations must never appear
   always @(negedge clk) begin
      checks++;
      if ((j & k) != '0 || (~ff_preset & ~ff_clear) != '0) begin
         errors++;
         $display("FAIL illegal_drive j=%b k=%b pre=%b clr=%b", j, k, ff_preset, ff_clear);
      end
   end

   // One full request with model-derived expectations
   task automatic run_req(input logic [W-1:0] t, input logic init);
      logic [W-1:0] ej, ek, ep, ec, obs;
      int n;
      bit seen;
      ej  = init ? '0 : (t & ~mdl_exp);
      ek  = init ? '0 : (~t & mdl_exp);
      ep  = init ? ~t : '1;
      ec  = init ? t  : '1;
      obs = stuck0 ? (t & 4'b1110) : t;
      n = 0;
      while (!tgt_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!tgt_ready) begin errors++; $display("FAIL ready_timeout got=%b want=1", tgt_ready); end
      tgt_valid = 1'b1; tgt_value = t; tgt_init = init;
      @(posedge clk); #1;
      tgt_valid = 1'b0;
      checks++;
      if ({j, k, ff_preset, ff_clear} !== {ej, ek, ep, ec}) begin
         errors++;
         $display("FAIL drive t=%b init=%b got j=%b k=%b pre=%b clr=%b want j=%b k=%b pre=%b clr=%b",
                  t, init, j, k, ff_preset, ff_clear, ej, ek, ep, ec);
      end
      checks++;
      if ({busy, tgt_ready, done} !== 3'b100) begin
         errors++; $display("FAIL drive_flags got busy/ready/done=%b want 100", {busy, tgt_ready, done});
      end
      seen = 0;
      for (n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (done) begin seen = 1; break; end
      end
      checks++;
      if (!seen || n != S + 2) begin
         errors++; $display("FAIL latency got=%0d want=%0d", seen ? n : -1, S + 2);
      end
      checks++;
      if ({mismatch, mismatch_bits, tgt_ready} !== {|(obs ^ t), obs ^ t, 1'b1}) begin
         errors++;
         $display("FAIL compare t=%b got mm=%b bits=%b rdy=%b want mm=%b bits=%b rdy=1",
                  t, mismatch, mismatch_bits, tgt_ready, |(obs ^ t), obs ^ t);
      end
      mdl_exp = obs;
      if (obs != t && mdl_err < 255) mdl_err++;
`ifdef JKDRV_ERR_COUNT_EN
      checks++;
      if (err_count !== 8'(mdl_err)) begin
         errors++; $display("FAIL err_count got=%0d want=%0d", err_count, mdl_err);
      end
`endif
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({ff_clear, ff_preset, j, k} !== {4'h0, 4'hF, 4'h0, 4'h0}) begin
         errors++; $display("FAIL reset_drive got clr=%b pre=%b j=%b k=%b", ff_clear, ff_preset, j, k);
      end
      checks++;
      if ({busy, tgt_ready, done, mismatch, mismatch_bits, q} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
         errors++; $display("FAIL reset_flags got busy=%b rdy=%b done=%b mm=%b bits=%b q=%b",
                            busy, tgt_ready, done, mismatch, mismatch_bits, q);
      end
`ifdef JKDRV_ERR_COUNT_EN
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
`endif
      clear = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({tgt_ready, busy, done, ff_clear, q} !== {1'b1, 1'b0, 1'b0, 4'hF, 4'h0}) begin
         errors++; $display("FAIL reset_release got rdy=%b busy=%b done=%b clr=%b q=%b want 1 0 0 1111 0000",
                            tgt_ready, busy, done, ff_clear, q);
      end
   endtask

   task automatic test_init_load();
      run_req(4'b1010, 1'b1);
      checks++;
      if (q !== 4'b1010) begin errors++; $display("FAIL init_q got=%b want=1010", q); end
   endtask

   task automatic test_jk_step();
      run_req(4'b0110, 1'b0);
      checks++;
      if (q !== 4'b0110) begin errors++; $display("FAIL step_q got=%b want=0110", q); end
   endtask

   task automatic test_fault();
      stuck0 = 1'b1;
      run_req(4'b0000, 1'b1);
      run_req(4'b0001, 1'b0);
      run_req(4'b0001, 1'b0);
      stuck0 = 1'b0;
      run_req(4'b0000, 1'b1);
   endtask

   task automatic test_reset_in_wait();
      bit seen;
      while (!tgt_ready) @(negedge clk);
      tgt_valid = 1'b1; tgt_value = 4'b1111; tgt_init = 1'b0;
      @(posedge clk); #1;
      tgt_valid = 1'b0;
      @(posedge clk); #1;
      clear = 1'b0;
      #1;
      checks++;
      if ({ff_clear, j, k, busy, tgt_ready, done, mismatch_bits, q} !==
          {4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0}) begin
         errors++; $display("FAIL reset_wait got clr=%b j=%b k=%b busy=%b rdy=%b done=%b bits=%b q=%b",
                            ff_clear, j, k, busy, tgt_ready, done, mismatch_bits, q);
      end
      repeat (2) @(negedge clk);
      clear = 1'b1;
      seen = 0;
      repeat (6) begin @(posedge clk); #1; if (done) seen = 1; end
      checks++;
      if (seen || !tgt_ready) begin
         errors++; $display("FAIL reset_wait_drop got done_seen=%b rdy=%b want 0 1", seen, tgt_ready);
      end
      mdl_exp = '0;
      run_req(4'b0001, 1'b0);   // j=0001 only if expect restarted at 0
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] seq [3];
      int acc [3];
      int dn [3];
      int na, nd;
      logic rdy;
      seq[0] = 4'b1111; seq[1] = 4'b0000; seq[2] = 4'b0011;
      na = 0; nd = 0;
      @(negedge clk);
      tgt_valid = 1'b1; tgt_value = seq[0]; tgt_init = 1'b0;
      for (int c = 0; c < 24; c++) begin
         rdy = tgt_ready;
         @(posedge clk); #1;
         if (rdy && na < 3) begin
            acc[na] = c; na++;
            if (na < 3) tgt_value = seq[na];
            else tgt_valid = 1'b0;
         end
         if (done && nd < 3) begin
            checks++;
            if (mismatch !== 1'b0 || q !== seq[nd]) begin
               errors++; $display("FAIL b2b_compare idx=%0d got mm=%b q=%b want 0 %b", nd, mismatch, q, seq[nd]);
            end
            dn[nd] = c; nd++;
         end
         @(negedge clk);
      end
      checks++;
      if (na != 3 || nd != 3) begin
         errors++; $display("FAIL b2b_count got acc=%0d done=%0d want 3 3", na, nd);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (dn[i] - acc[i] != S + 2 || (i > 0 && dn[i] - dn[i-1] != S + 3)) begin
               errors++; $display("FAIL b2b_spacing idx=%0d got acc=%0d done=%0d", i, acc[i], dn[i]);
            end
         end
      end
      mdl_exp = seq[2];
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         run_req(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      fork
         begin
            test_reset();
            test_init_load();
            test_jk_step();
            test_fault();
            test_reset_in_wait();
            test_back_to_back();
            test_random();
         end
         begin
            #200000;
            $display("FAIL global_timeout");
            $fatal(1, "timeout");
         end
      join_any
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
